// File: rtl/ahb_arbiter.sv
// ahb_arbiter: two-master AHB-Lite arbiter with parking, burst beat limit and data-phase mux
module ahb_arbiter #(
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_BEATS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HBUSREQ0,
  input  logic        HBUSREQ1,
  input  logic [31:0] HADDR0,
  input  logic [31:0] HADDR1,
  input  logic [1:0]  HTRANS0,
  input  logic [1:0]  HTRANS1,
  input  logic        HWRITE0,
  input  logic        HWRITE1,
  input  logic [31:0] HWDATA0,
  input  logic [31:0] HWDATA1,
  input  logic        HREADY,
  output logic        HGRANT0,
  output logic        HGRANT1,
  output logic        HMASTER,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA
);
  typedef enum logic [1:0] {PARK, OWN0, OWN1} state_t;
  localparam logic DM = 1'(DEFAULT_MASTER);
  localparam logic [7:0] MAXB = 8'(MAX_BEATS);
  state_t state_q, state_d;
  logic [7:0] beat_q, beat_d;
  logic last_q, last_d, dmaster_q;
  logic own_req, oth_req, release_c, force_c;
  // Address owner follows the state directly so grant and mux switch on the same edge
  always_comb begin
    HMASTER = state_q == OWN1 ? 1'b1 : state_q == OWN0 ? 1'b0 : DM;
    HGRANT0 = ~HMASTER;
    HGRANT1 = HMASTER;
    HADDR   = HMASTER ? HADDR1 : HADDR0;
    HTRANS  = HMASTER ? HTRANS1 : HTRANS0;
    HWRITE  = HMASTER ? HWRITE1 : HWRITE0;
    HWDATA  = dmaster_q ? HWDATA1 : HWDATA0;
    own_req = HMASTER ? HBUSREQ1 : HBUSREQ0;
    oth_req = HMASTER ? HBUSREQ0 : HBUSREQ1;
  end
  // Arbitration: park choice, voluntary release on IDLE/NONSEQ, forced release at beat limit
  always_comb begin
    state_d   = state_q;
    release_c = !own_req && (HTRANS == 2'b00 || HTRANS == 2'b10);
    force_c   = beat_q == MAXB && oth_req;
    if (HREADY) begin
      if (state_q == PARK)
        state_d = (HBUSREQ0 && HBUSREQ1) ? (last_q ? OWN0 : OWN1) :
                  HBUSREQ0 ? OWN0 : HBUSREQ1 ? OWN1 : PARK;
      else if (force_c || release_c)
        state_d = oth_req ? (HMASTER ? OWN0 : OWN1) : PARK;
    end
    beat_d = !HREADY ? beat_q :
             (state_d == PARK || state_d != state_q) ? 8'd0 :
             (HTRANS[1] && beat_q != MAXB) ? beat_q + 8'd1 : beat_q;
    last_d = state_d == OWN0 ? 1'b0 : state_d == OWN1 ? 1'b1 : last_q;
  end
  // State, beat counter, fairness memory and data-phase owner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PARK;
      beat_q    <= 8'd0;
      last_q    <= ~DM;
      dmaster_q <= DM;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
      dmaster_q <= HREADY ? HMASTER : dmaster_q;
    end
  end
endmodule
